// File: rtl/accel_poll_ctrl.sv
// Accelerometer poll controller: issues one MODE write, waits for the sensor
// to settle, then reads X/Y/Z in a fixed order. Each round is published
// together as one sign-extended sample set. Rounds repeat every PERIOD_CYC
// cycles while enable is held high.
module accel_poll_ctrl #(
    parameter logic [6:0] DEV_ADDR    = 7'h4C,
    parameter int         SETTLE_CYC  = 2000,
    parameter int         PERIOD_CYC  = 48000,
    parameter int         MAX_RETRY   = 3,
    parameter int         ALERT_RETRY = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       txn_req,
    output logic       txn_rw,
    output logic [6:0] txn_dev,
    output logic [7:0] txn_reg,
    output logic [7:0] txn_wdata,
    input  logic       txn_done,
    input  logic       txn_nack,
    input  logic [7:0] txn_rdata,
    output logic [7:0] xout,
    output logic [7:0] yout,
    output logic [7:0] zout,
    output logic       data_valid,
    output logic       busy,
    output logic       err
);

    localparam int CNT_MAX = (SETTLE_CYC > PERIOD_CYC) ? SETTLE_CYC : PERIOD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTY_W   = $clog2(MAX_RETRY + 1) + 1;
    localparam int ALT_W   = $clog2(ALERT_RETRY + 1) + 1;

    localparam logic [1:0] AX_X = 2'd0;
    localparam logic [1:0] AX_Y = 2'd1;
    localparam logic [1:0] AX_Z = 2'd2;

    typedef enum logic [2:0] {IDLE, CFG_REQ, SETTLE, RD_REQ, PERIOD, ERROR} state_t;

    state_t                    state, state_nxt;
    logic                      req_nxt, rw_nxt, dv_nxt, err_nxt;
    logic        [7:0]         reg_nxt, wdata_nxt;
    logic        [1:0]         axis, axis_nxt;
    logic        [CNT_W-1:0]   cnt, cnt_nxt;
    logic        [RTY_W-1:0]   retry_cnt, retry_nxt;
    logic        [ALT_W-1:0]   alert_cnt, alert_nxt;
    logic signed [7:0]         x_sh, y_sh, x_sh_nxt, y_sh_nxt;
    logic        [7:0]         xout_nxt, yout_nxt, zout_nxt;
    logic signed [7:0]         sample;
    logic                      rdata_unused;

    // The sensor returns a 6-bit two's-complement value; bit 6 is Alert, bit 7 is don't-care.
    function automatic logic signed [7:0] sext6(input logic [7:0] d);
        return {d[5], d[5], d[5:0]};
    endfunction

    assign sample       = sext6(txn_rdata);
    assign rdata_unused = txn_rdata[7];
    assign txn_dev      = DEV_ADDR;
    assign busy         = (state != IDLE);

    // Next-state and next-output decode; a done pulse only counts while a request is up.
    always_comb begin
        state_nxt = state;
        req_nxt   = txn_req;
        rw_nxt    = txn_rw;
        reg_nxt   = txn_reg;
        wdata_nxt = txn_wdata;
        axis_nxt  = axis;
        cnt_nxt   = '0;
        retry_nxt = retry_cnt;
        alert_nxt = alert_cnt;
        err_nxt   = err;
        dv_nxt    = 1'b0;
        x_sh_nxt  = x_sh;
        y_sh_nxt  = y_sh;
        xout_nxt  = xout;
        yout_nxt  = yout;
        zout_nxt  = zout;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = CFG_REQ;
                    err_nxt   = 1'b0;
                    retry_nxt = '0;
                    alert_nxt = '0;
                    axis_nxt  = AX_X;
                end
            end

            CFG_REQ, RD_REQ: begin
                if (!txn_req) begin
                    // Request slot free: start (or restart) the transaction unless told to stop.
                    if (!enable) begin
                        state_nxt = IDLE;
                    end else begin
                        req_nxt = 1'b1;
                        if (state == CFG_REQ) begin
                            rw_nxt    = 1'b0;
                            reg_nxt   = 8'h07;
                            wdata_nxt = 8'h01;
                        end else begin
                            rw_nxt    = 1'b1;
                            reg_nxt   = {6'b0, axis};
                            wdata_nxt = 8'h00;
                        end
                    end
                end else if (txn_done) begin
                    req_nxt = 1'b0;
                    if (!enable) begin
                        // Partial round: finish the bus cycle but publish nothing.
                        state_nxt = IDLE;
                    end else if (txn_nack) begin
                        if (retry_cnt == RTY_W'(MAX_RETRY)) begin
                            state_nxt = ERROR;
                            err_nxt   = 1'b1;
                        end else begin
                            retry_nxt = retry_cnt + 1'b1;
                        end
                    end else begin
                        retry_nxt = '0;
                        if (state == CFG_REQ) begin
                            alert_nxt = '0;
                            state_nxt = SETTLE;
                        end else if (txn_rdata[6]) begin
                            // Alert: sample unreliable, re-read the same axis.
                            if (alert_cnt == ALT_W'(ALERT_RETRY)) begin
                                state_nxt = ERROR;
                                err_nxt   = 1'b1;
                            end else begin
                                alert_nxt = alert_cnt + 1'b1;
                            end
                        end else begin
                            alert_nxt = '0;
                            case (axis)
                                AX_X: begin
                                    x_sh_nxt = sample;
                                    axis_nxt = AX_Y;
                                end
                                AX_Y: begin
                                    y_sh_nxt = sample;
                                    axis_nxt = AX_Z;
                                end
                                default: begin
                                    xout_nxt  = x_sh;
                                    yout_nxt  = y_sh;
                                    zout_nxt  = sample;
                                    dv_nxt    = 1'b1;
                                    axis_nxt  = AX_X;
                                    state_nxt = PERIOD;
                                end
                            endcase
                        end
                    end
                end
            end

            SETTLE: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                    state_nxt = RD_REQ;
                    axis_nxt  = AX_X;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            PERIOD: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_W'(PERIOD_CYC - 1)) begin
                    state_nxt = RD_REQ;
                    axis_nxt  = AX_X;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ERROR: begin
                req_nxt = 1'b0;
                if (!enable) state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

    // State, handshake and sample registers; reset drops any request in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            txn_req    <= 1'b0;
            txn_rw     <= 1'b0;
            txn_reg    <= 8'h00;
            txn_wdata  <= 8'h00;
            axis       <= AX_X;
            cnt        <= '0;
            retry_cnt  <= '0;
            alert_cnt  <= '0;
            err        <= 1'b0;
            data_valid <= 1'b0;
            x_sh       <= '0;
            y_sh       <= '0;
            xout       <= 8'h00;
            yout       <= 8'h00;
            zout       <= 8'h00;
        end else begin
            state      <= state_nxt;
            txn_req    <= req_nxt;
            txn_rw     <= rw_nxt;
            txn_reg    <= reg_nxt;
            txn_wdata  <= wdata_nxt;
            axis       <= axis_nxt;
            cnt        <= cnt_nxt;
            retry_cnt  <= retry_nxt;
            alert_cnt  <= alert_nxt;
            err        <= err_nxt;
            data_valid <= dv_nxt;
            x_sh       <= x_sh_nxt;
            y_sh       <= y_sh_nxt;
            xout       <= xout_nxt;
            yout       <= yout_nxt;
            zout       <= zout_nxt;
        end
    end

endmodule
